// File: rtl/inst_axi_responder_if.sv
// Bundle of the fetch-side request/response and AXI read-channel signals of inst_axi_responder.
// The master modport is the responder's view; the slave modport is the CPU/AXI environment's view.
interface inst_axi_responder_if;
  logic        inst_valid;
  logic        inst_op;
  logic [31:0] inst_addr;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_wdata;
  logic        inst_uncache_en;
  logic        inst_cancel;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        icache_miss;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  // Handshake rule on both sides: a transfer happens on a rising edge where
  // valid and ready are both high; a raised arvalid stays up until arready.
  modport master (
    input  inst_valid, inst_op, inst_addr, inst_wstrb, inst_wdata,
           inst_uncache_en, inst_cancel,
    output inst_addr_ok, inst_data_ok, inst_rdata, icache_miss,
    output arid, araddr, arlen, arsize, arburst, arcache, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    output inst_valid, inst_op, inst_addr, inst_wstrb, inst_wdata,
           inst_uncache_en, inst_cancel,
    input  inst_addr_ok, inst_data_ok, inst_rdata, icache_miss,
    input  arid, araddr, arlen, arsize, arburst, arcache, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/inst_axi_responder.sv
// Single-outstanding instruction fetch bridge onto an AXI read channel (IDLE/AR/R/DROP FSM).
// Optional fetch counter output perf_fetch_cnt is enabled with macro INST_RESP_PERF_EN.
module inst_axi_responder #(
  parameter logic [3:0] AR_ID = 4'h0
) (
  input  logic                 clk,
  input  logic                 resetn,
  inst_axi_responder_if.master bus,
`ifdef INST_RESP_PERF_EN
  output logic [31:0]          perf_fetch_cnt,
`endif
  output logic [1:0]           state_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AR   = 2'd1;
  localparam logic [1:0] S_R    = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        cancel_ar_q, cancel_ar_d;
  logic [31:0] araddr_q, araddr_d;
  logic [3:0]  arcache_q, arcache_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [31:0] rhold_q, rhold_d;
  logic        pend_q, pend_d;
  logic        accept;
  logic        data_ok;
  logic        unused_sig;

  assign accept  = bus.inst_valid && !bus.inst_op && (state_q == S_IDLE) && !bus.inst_cancel;
  // A flush arriving in the delivery cycle still kills the pulse.
  assign data_ok = pend_q && !bus.inst_cancel;

  always_comb begin
    state_d     = state_q;
    cancel_ar_d = cancel_ar_q;
    araddr_d    = araddr_q;
    arcache_d   = arcache_q;
    rbuf_d      = rbuf_q;
    rhold_d     = data_ok ? rbuf_q : rhold_q;
    pend_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d     = S_AR;
          araddr_d    = bus.inst_addr;
          arcache_d   = bus.inst_uncache_en ? 4'b0000 : 4'b1111;
          cancel_ar_d = 1'b0;
        end
      end
      S_AR: begin
        // The address beat cannot be withdrawn, so remember the flush until arready.
        if (bus.inst_cancel) cancel_ar_d = 1'b1;
        if (bus.arready) state_d = (cancel_ar_q || bus.inst_cancel) ? S_DROP : S_R;
      end
      S_R: begin
        if (bus.rvalid) begin
          state_d = S_IDLE;
          if (!bus.inst_cancel) begin
            rbuf_d = bus.rdata;
            pend_d = 1'b1;
          end
        end else if (bus.inst_cancel) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (bus.rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cancel_ar_q <= 1'b0;
      araddr_q    <= '0;
      arcache_q   <= '0;
      rbuf_q      <= '0;
      rhold_q     <= '0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cancel_ar_q <= cancel_ar_d;
      araddr_q    <= araddr_d;
      arcache_q   <= arcache_d;
      rbuf_q      <= rbuf_d;
      rhold_q     <= rhold_d;
      pend_q      <= pend_d;
    end
  end

  assign bus.inst_addr_ok = accept;
  assign bus.inst_data_ok = data_ok;
  assign bus.icache_miss  = data_ok;
  assign bus.inst_rdata   = data_ok ? rbuf_q : rhold_q;
  assign bus.arvalid      = (state_q == S_AR);
  assign bus.arid         = AR_ID;
  assign bus.araddr       = araddr_q;
  assign bus.arlen        = 8'd0;
  assign bus.arsize       = 3'b010;
  assign bus.arburst      = 2'b01;
  assign bus.arcache      = arcache_q;
  assign bus.rready       = (state_q == S_R) || (state_q == S_DROP);
  assign state_o          = state_q;

  // Write payload and the R-channel side fields carry no information for a single-beat fetch.
  assign unused_sig = ^{bus.inst_wstrb, bus.inst_wdata, bus.rid, bus.rresp, bus.rlast};

`ifdef INST_RESP_PERF_EN
  logic [31:0] perf_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) perf_cnt_q <= '0;
    else if (data_ok) perf_cnt_q <= perf_cnt_q + 32'd1;
  end

  assign perf_fetch_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_inst_axi_responder.sv
// Bench for inst_axi_responder: fetch driver with AXI slave emulation, latency/data model in
// expectation queues, and a negedge monitor that pops and compares on every DUT response.
module tb_inst_axi_responder;
  localparam logic [3:0] AR_ID = 4'h5;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [1:0] state_o;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit stray_r = 1'b0;
  logic [31:0] last_rdata = '0;
  logic [31:0] n_ok = '0;

  logic [31:0] exp_araddr_q[$];
  logic [3:0]  exp_arcache_q[$];
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];

  inst_axi_responder_if bus_if ();

`ifdef INST_RESP_PERF_EN
  logic [31:0] perf_fetch_cnt;
`endif

  inst_axi_responder #(.AR_ID(AR_ID)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .bus            (bus_if.master),
`ifdef INST_RESP_PERF_EN
    .perf_fetch_cnt (perf_fetch_cnt),
`endif
    .state_o        (state_o)
  );

  // Clock and reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!resetn) begin
      last_rdata = '0;
      n_ok = '0;
    end else begin
      if (bus_if.arvalid) begin
        if (exp_araddr_q.size() == 0) begin
          check("arvalid without request", 32'(bus_if.arvalid), 32'd0);
        end else begin
          check("araddr", bus_if.araddr, exp_araddr_q[0]);
          check("arcache", 32'(bus_if.arcache), 32'(exp_arcache_q[0]));
          check("ar fixed fields", {bus_if.arid, bus_if.arlen, bus_if.arsize, bus_if.arburst},
                {AR_ID, 8'd0, 3'b010, 2'b01});
          if (!bus_if.arready) check("addr_ok during AR stall", 32'(bus_if.inst_addr_ok), 32'd0);
          else begin
            void'(exp_araddr_q.pop_front());
            void'(exp_arcache_q.pop_front());
          end
        end
      end
      if (bus_if.rvalid && !stray_r) check("rready with rvalid", 32'(bus_if.rready), 32'd1);
      if (bus_if.inst_data_ok) begin
        n_ok = n_ok + 32'd1;
        if (exp_q.size() == 0) begin
          check("unexpected inst_data_ok", 32'(bus_if.inst_data_ok), 32'd0);
        end else begin
          last_rdata = exp_q.pop_front();
          check("inst_rdata", bus_if.inst_rdata, last_rdata);
          check("data_ok cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
          check("icache_miss with data_ok", 32'(bus_if.icache_miss), 32'd1);
        end
      end else begin
        check("inst_rdata hold", bus_if.inst_rdata, last_rdata);
        check("icache_miss idle", 32'(bus_if.icache_miss), 32'd0);
      end
    end
  end

  // Driver. Called and returning at posedge+1. mode: 0 normal, 1 cancel in AR,
  // 2 cancel in R before rvalid, 3 cancel with rvalid, 4 cancel in delivery cycle.
  task automatic fetch(input logic [31:0] addr, input bit unc, input int ar_dly, input int r_dly,
                       input int mode, output int acc);
    logic [31:0] data;
    bit got;
    data = $urandom;
    bus_if.inst_valid = 1'b1;
    bus_if.inst_op = 1'b0;
    bus_if.inst_addr = addr;
    bus_if.inst_uncache_en = unc;
    bus_if.inst_wdata = $urandom;
    bus_if.inst_wstrb = 4'($urandom_range(0, 15));
    got = 1'b0;
    acc = -1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus_if.inst_addr_ok) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!got) begin
      check("accept timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      bus_if.inst_valid = 1'b0;
      return;
    end
    acc = cyc;
    exp_araddr_q.push_back(addr);
    exp_arcache_q.push_back(unc ? 4'h0 : 4'hF);
    if (mode == 0) begin
      exp_q.push_back(data);
      exp_cyc_q.push_back(acc + 3 + ar_dly + r_dly);
    end
    @(posedge clk); #1;
    bus_if.inst_valid = 1'b0;
    if (mode == 1) bus_if.inst_cancel = 1'b1;
    repeat (ar_dly) begin @(posedge clk); #1; bus_if.inst_cancel = 1'b0; end
    bus_if.arready = 1'b1;
    @(posedge clk); #1;
    bus_if.arready = 1'b0;
    bus_if.inst_cancel = 1'b0;
    if (mode == 2) bus_if.inst_cancel = 1'b1;
    repeat (r_dly) begin @(posedge clk); #1; bus_if.inst_cancel = 1'b0; end
    bus_if.rvalid = 1'b1;
    bus_if.rdata = data;
    bus_if.rresp = 2'($urandom_range(0, 3));
    bus_if.rid = AR_ID;
    bus_if.rlast = 1'b1;
    if (mode == 3) bus_if.inst_cancel = 1'b1;
    @(posedge clk); #1;
    bus_if.rvalid = 1'b0;
    bus_if.rdata = $urandom;
    bus_if.inst_cancel = 1'b0;
    if (mode == 4) begin
      bus_if.inst_cancel = 1'b1;
      @(posedge clk); #1;
      bus_if.inst_cancel = 1'b0;
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    check({name, " state"}, 32'(state_o), 32'd0);
    check({name, " arvalid/rready"}, {30'd0, bus_if.arvalid, bus_if.rready}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic try_write();
    bus_if.inst_valid = 1'b1;
    bus_if.inst_op = 1'b1;
    bus_if.inst_addr = 32'h1c000100;
    repeat (3) begin
      @(negedge clk);
      check("write refused", 32'(bus_if.inst_addr_ok), 32'd0);
      @(posedge clk); #1;
    end
    bus_if.inst_valid = 1'b0;
    bus_if.inst_op = 1'b0;
  endtask

  task automatic check_reset_values(input string name);
    check({name, " arvalid"}, 32'(bus_if.arvalid), 32'd0);
    check({name, " rready"}, 32'(bus_if.rready), 32'd0);
    check({name, " data_ok"}, 32'(bus_if.inst_data_ok), 32'd0);
    check({name, " icache_miss"}, 32'(bus_if.icache_miss), 32'd0);
    check({name, " inst_rdata"}, bus_if.inst_rdata, 32'd0);
    check({name, " araddr"}, bus_if.araddr, 32'd0);
    check({name, " arcache"}, 32'(bus_if.arcache), 32'd0);
    check({name, " state"}, 32'(state_o), 32'd0);
`ifdef INST_RESP_PERF_EN
    check({name, " perf_fetch_cnt"}, perf_fetch_cnt, 32'd0);
`endif
  endtask

  initial begin
    int a0, a1, ad, rd, md;
    bus_if.inst_valid = 1'b0;
    bus_if.inst_op = 1'b0;
    bus_if.inst_addr = '0;
    bus_if.inst_wstrb = '0;
    bus_if.inst_wdata = '0;
    bus_if.inst_uncache_en = 1'b0;
    bus_if.inst_cancel = 1'b0;
    bus_if.arready = 1'b0;
    bus_if.rid = '0;
    bus_if.rdata = '0;
    bus_if.rresp = '0;
    bus_if.rlast = 1'b0;
    bus_if.rvalid = 1'b0;
    #12;
    check_reset_values("reset");
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Single fetch with immediate arready/rvalid: data at T+3.
    fetch(32'h1c000000, 1'b0, 0, 0, 0, a0);
    check_idle("after single");
    // Back-to-back: second accept in the first delivery cycle.
    fetch(32'h1c000000, 1'b0, 0, 0, 0, a0);
    fetch(32'h1c000004, 1'b0, 0, 0, 0, a1);
    check("b2b second accept cycle", 32'(a1), 32'(a0 + 3));
    check_idle("after b2b");
    // AR stall of 5 cycles.
    fetch(32'h1c000040, 1'b1, 5, 0, 0, a0);
    // Cancels in AR, in R, coincident with rvalid, in the delivery cycle.
    fetch(32'h1c000080, 1'b0, 2, 1, 1, a0);
    check_idle("after cancel AR");
    fetch(32'h1c000084, 1'b0, 0, 3, 2, a0);
    check_idle("after cancel R");
    fetch(32'h1c000088, 1'b1, 1, 0, 3, a0);
    check_idle("after cancel rvalid");
    fetch(32'h1c00008c, 1'b0, 0, 0, 4, a0);
    check_idle("after cancel delivery");
    fetch(32'h1c000090, 1'b0, 0, 0, 0, a0);
    // Uncached and write requests.
    fetch(32'h1c0000a0, 1'b1, 0, 2, 0, a0);
    try_write();

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      ad = $urandom_range(0, 3);
      rd = $urandom_range(0, 3);
      md = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      if (md == 2 && rd == 0) rd = 1;
      fetch({$urandom_range(0, 32'h0fffffff), 2'b00}, 1'($urandom_range(0, 1)), ad, rd, md, a0);
    end
    check_idle("after random");

    // Reset while waiting for R data abandons the fetch.
    bus_if.inst_valid = 1'b1;
    bus_if.inst_addr = 32'h1c000200;
    @(negedge clk);
    check("reset test accept", 32'(bus_if.inst_addr_ok), 32'd1);
    exp_araddr_q.push_back(32'h1c000200);
    exp_arcache_q.push_back(4'hF);
    @(posedge clk); #1;
    bus_if.inst_valid = 1'b0;
    bus_if.arready = 1'b1;
    @(posedge clk); #1;
    bus_if.arready = 1'b0;
    resetn = 1'b0;
    #2;
    check_reset_values("mid-R reset");
    @(posedge clk); #1;
    resetn = 1'b1;
    stray_r = 1'b1;
    bus_if.rvalid = 1'b1;
    bus_if.rdata = 32'hdeadbeef;
    @(posedge clk); #1;
    bus_if.rvalid = 1'b0;
    stray_r = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check_idle("after mid-R reset");
    fetch(32'h1c000300, 1'b0, 1, 1, 0, a0);

`ifdef INST_RESP_PERF_EN
    check("perf count", perf_fetch_cnt, n_ok);
    force dut.perf_cnt_q = 32'hFFFFFFFF;
    @(posedge clk); #1;
    release dut.perf_cnt_q;
    fetch(32'h1c000400, 1'b0, 0, 0, 0, a0);
    repeat (2) begin @(posedge clk); #1; end
    check("perf wrap", perf_fetch_cnt, 32'd0);
`endif

    repeat (4) begin @(posedge clk); #1; end
    check("ar queue drained", 32'(exp_araddr_q.size()), 32'd0);
    check("data queue drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/inst_axi_responder.md
INST_AXI_RESPONDER -- requirements
Module: inst_axi_responder

Interface
REQ-001 Parameter: AR_ID, default 4'h0, constant arid value driven on every read request.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 inst_valid / inst_op  in  1/1  fetch request valid; op=1 (write) is never accepted.
REQ-005 inst_addr  in  32  fetch address, word aligned.
REQ-006 inst_wstrb / inst_wdata  in  4/32  ignored.
REQ-007 inst_uncache_en  in  1  selects arcache value.
REQ-008 inst_cancel  in  1  flush; discards the in-flight fetch response.
REQ-009 inst_addr_ok  out  1  request accepted this cycle.
REQ-010 inst_data_ok  out  1  one-cycle pulse, inst_rdata valid.
REQ-011 inst_rdata  out  32  fetched instruction word.
REQ-012 icache_miss  out  1  high with every inst_data_ok (all fetches go to the bus).
REQ-013 arid/araddr/arlen/arsize/arburst/arcache  out  4/32/8/3/2/4  AXI read address.
REQ-014 arvalid out 1, arready in 1  AXI AR handshake.
REQ-015 rid/rdata/rresp/rlast/rvalid in 4/32/2/1/1, rready out 1  AXI R channel.

Function
REQ-016 The FSM SHALL have states IDLE, AR, R, DROP; at most one fetch outstanding.
REQ-017 inst_addr_ok SHALL equal inst_valid && !inst_op && state==IDLE && !inst_cancel (combinational).
REQ-018 On acceptance, araddr SHALL latch inst_addr and arcache SHALL latch inst_uncache_en ? 4'b0000 : 4'b1111, and the state SHALL go IDLE->AR.
REQ-019 In AR, arvalid SHALL be 1 with arlen=0, arsize=3'b010, arburst=2'b01, arid=AR_ID; on arready the state SHALL go to R.
REQ-020 In R and DROP, rready SHALL be 1; arvalid SHALL be 0 outside AR.
REQ-021 On rvalid&&rready in R, rdata SHALL be registered and inst_data_ok/icache_miss SHALL pulse high the following cycle; the state SHALL return to IDLE in that same following cycle.
REQ-022 Latency: request accepted at cycle T with arready at T+1 and rvalid at T+2 SHALL give inst_data_ok at T+3.
REQ-023 The cycle carrying inst_data_ok SHALL be IDLE, so a new request may be accepted in that cycle (back-to-back).
REQ-024 inst_cancel in AR SHALL keep arvalid asserted until arready (AXI rule), then go to DROP.
REQ-025 inst_cancel in R, without rvalid in the same cycle, SHALL go to DROP; with rvalid in the same cycle, the state SHALL go to IDLE and suppress inst_data_ok.
REQ-026 In DROP, rvalid SHALL return the state to IDLE with no inst_data_ok.
REQ-027 inst_cancel in IDLE SHALL suppress a pending inst_data_ok pulse scheduled for that cycle.
REQ-028 Data with rresp!=0 SHALL be delivered unchanged; no error signalling.
REQ-029 inst_rdata SHALL hold its last value until the next inst_data_ok.

Reset
REQ-030 With resetn low: state=IDLE, arvalid=0, rready=0, inst_data_ok=0, icache_miss=0, inst_rdata=0, araddr=0, arcache=0; the counter in REQ-032 SHALL also be 0.
REQ-031 Reset asserted mid-fetch SHALL abandon the fetch; after release no inst_data_ok for it.

Configuration
REQ-032 With INST_RESP_PERF_EN defined: add output perf_fetch_cnt[31:0], which SHALL increment on each inst_data_ok and wrap 32'hFFFFFFFF->0. Without the macro: the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Single fetch at 0x1c000000, arready/rvalid immediate, rdata=0x02800000 -> inst_data_ok at T+3 with inst_rdata=0x02800000 and icache_miss=1.
REQ-034 Two back-to-back fetches 0x1c000000/0x1c000004 -> second inst_addr_ok in the first inst_data_ok cycle; two araddr values in order.
REQ-035 arready held low 5 cycles -> arvalid and araddr stable and inst_addr_ok=0 throughout.
REQ-036 inst_cancel in AR, then in R, then coincident with rvalid -> no inst_data_ok in any case; IDLE afterwards; the next fetch returns correct data.
REQ-037 inst_uncache_en=1 -> arcache=0; inst_uncache_en=0 -> arcache=4'hF; inst_op=1 -> no inst_addr_ok.
REQ-038 With INST_RESP_PERF_EN and the counter preset to 32'hFFFFFFFF via force -> one fetch gives 0; reset mid-R gives state IDLE and counter 0.
